// File: rtl/lane_mask_iterator_if.sv
// Handshake bundle for lane_mask_iterator: mask input channel, index output
// channel and the busy status flag.
//
// Valid/ready rule for both channels: the producer raises valid with stable
// payload, a transfer happens on every rising clock edge where valid && ready
// are both high, and the producer may not drop valid or change the payload
// until that transfer has happened.
interface lane_mask_iterator_if #(
    parameter int W     = 32,
    parameter int W_IDX = $clog2(W),
    parameter int W_TAG = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_mask;
    logic [W_TAG-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W_IDX-1:0] out_idx;
    logic [W_TAG-1:0] out_tag;
    logic             out_last;
    logic             busy;

    // Environment side: offers masks and consumes indices.
    modport master (
        output in_valid, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_idx, out_tag, out_last, busy
    );

    // Iterator side.
    modport slave (
        input  in_valid, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_idx, out_tag, out_last, busy
    );
endinterface

// File: rtl/lane_mask_iterator.sv
// Serialises a lane bitmask into a stream of lane indices, lowest set bit
// first, one index per cycle. A new mask can be taken on the same edge that
// retires the last index of the previous one, so masks stream back to back.
module lane_mask_iterator #(
    parameter int W     = 32,
    parameter int W_IDX = $clog2(W),
    parameter int W_TAG = 8
) (
    input logic                 clk,
    input logic                 reset,
    lane_mask_iterator_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [W-1:0]     mask_r;
    logic [W-1:0]     mask_nxt;
    logic [W_TAG-1:0] tag_r;
    logic [W_TAG-1:0] tag_nxt;

    logic [W-1:0]     mask_rest;
    logic             is_last;
    logic             out_valid;
    logic             out_fire;
    logic             in_ready;
    logic             in_fire;

    // Index of the lowest set bit; zero for an all-zero mask.
    function automatic logic [W_IDX-1:0] ctz(input logic [W-1:0] m);
        logic [W_IDX-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (m[i]) r = W_IDX'(i);
        end
        return r;
    endfunction

    // Remaining mask once the current lowest bit has been emitted.
    assign mask_rest = mask_r & (mask_r - W'(1));
    assign is_last   = (mask_rest == '0);

    // Outputs are forced quiet while reset is held so nothing downstream
    // sees a beat from a mask that is being dropped.
    assign out_valid = (state_r == ITER) && !reset;
    assign out_fire  = out_valid && bus.out_ready;
    assign in_ready  = !reset && ((state_r == IDLE) || (out_fire && is_last));
    assign in_fire   = bus.in_valid && in_ready;

    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign bus.busy      = out_valid;
    assign bus.out_idx   = out_valid ? ctz(mask_r) : '0;
    assign bus.out_tag   = out_valid ? tag_r : '0;
    assign bus.out_last  = out_valid && is_last;

    // Next-state: retire one bit per handshake, reload on accept.
    always_comb begin
        state_nxt = state_r;
        mask_nxt  = mask_r;
        tag_nxt   = tag_r;
        if (out_fire) begin
            mask_nxt = mask_rest;
            if (is_last) state_nxt = IDLE;
        end
        if (in_fire) begin
            if (bus.in_mask != '0) begin
                mask_nxt  = bus.in_mask;
                tag_nxt   = bus.in_tag;
                state_nxt = ITER;
            end else begin
                // An empty mask has nothing to emit and is simply consumed.
                state_nxt = IDLE;
            end
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mask_r  <= '0;
            tag_r   <= '0;
        end else begin
            state_r <= state_nxt;
            mask_r  <= mask_nxt;
            tag_r   <= tag_nxt;
        end
    end

endmodule

// File: tb/tb_lane_mask_iterator.sv
// Directed bench for lane_mask_iterator with hand-computed expectations.
module tb_lane_mask_iterator;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    lane_mask_iterator_if #(.W(32), .W_TAG(8)) bus ();

    lane_mask_iterator #(.W(32), .W_TAG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input int t, input int last);
        chk({tag, ".valid"}, 32'(bus.out_valid), 1);
        chk({tag, ".idx"},   32'(bus.out_idx),   idx);
        chk({tag, ".tag"},   32'(bus.out_tag),   t);
        chk({tag, ".last"},  32'(bus.out_last),  last);
        chk({tag, ".busy"},  32'(bus.busy),      1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 0);
        chk({tag, ".ready"}, 32'(bus.in_ready),  1);
        chk({tag, ".busy"},  32'(bus.busy),      0);
        chk({tag, ".idx"},   32'(bus.out_idx),   0);
        chk({tag, ".tag"},   32'(bus.out_tag),   0);
        chk({tag, ".last"},  32'(bus.out_last),  0);
    endtask

    task automatic offer(input logic [31:0] mask, input logic [7:0] t);
        bus.in_valid = 1'b1;
        bus.in_mask  = mask;
        bus.in_tag   = t;
    endtask

    task automatic withdraw();
        bus.in_valid = 1'b0;
        bus.in_mask  = 32'hDEAD_BEEF;
        bus.in_tag   = 8'hEE;
    endtask

    // Directed sequence.
    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset behaviour.
        tick();
        tick();
        chk("rst.in_ready", 32'(bus.in_ready), 0);
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        reset = 1'b0;
        settle();
        chk_idle("post_rst");

        // 1: three sparse bits, out_ready held high.
        offer(32'h8000_0101, 8'h5A);
        settle();
        chk("t1.accept_ready", 32'(bus.in_ready), 1);
        tick();
        withdraw();
        settle();
        chk_beat("t1.b0", 0, 8'h5A, 0);
        chk("t1.b0_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk_beat("t1.b1", 8, 8'h5A, 0);
        tick();
        chk_beat("t1.b2", 31, 8'h5A, 1);
        chk("t1.last_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk_idle("t1.end");

        // 2: two masks back to back with no bubble.
        offer(32'h1, 8'h11);
        tick();
        offer(32'h6, 8'h22);
        settle();
        chk_beat("t2.b0", 0, 8'h11, 1);
        chk("t2.b0_in_ready", 32'(bus.in_ready), 1);
        tick();
        withdraw();
        settle();
        chk_beat("t2.b1", 1, 8'h22, 0);
        chk("t2.b1_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk_beat("t2.b2", 2, 8'h22, 1);
        chk("t2.b2_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk_idle("t2.end");

        // 3: stalls between beats; outputs must hold, input changes ignored.
        offer(32'hF0, 8'h33);
        tick();
        withdraw();
        for (int k = 4; k <= 7; k++) begin
            bus.out_ready = 1'b0;
            settle();
            chk_beat("t3.stall_a", k, 8'h33, (k == 7) ? 1 : 0);
            chk("t3.stall_in_ready", 32'(bus.in_ready), 0);
            tick();
            bus.in_mask = 32'h0000_0003;
            settle();
            chk_beat("t3.stall_b", k, 8'h33, (k == 7) ? 1 : 0);
            bus.out_ready = 1'b1;
            settle();
            chk_beat("t3.go", k, 8'h33, (k == 7) ? 1 : 0);
            tick();
        end
        chk_idle("t3.end");

        // 4: empty mask is swallowed, then a single-bit mask.
        offer(32'h0, 8'h44);
        tick();
        withdraw();
        settle();
        chk_idle("t4.empty");
        tick();
        chk_idle("t4.empty2");
        offer(32'h4, 8'h55);
        tick();
        withdraw();
        settle();
        chk_beat("t4.b0", 2, 8'h55, 1);
        tick();
        chk_idle("t4.end");

        // 5: all lanes set.
        offer(32'hFFFF_FFFF, 8'h66);
        tick();
        withdraw();
        for (int i = 0; i < 32; i++) begin
            settle();
            chk_beat("t5.beat", i, 8'h66, (i == 31) ? 1 : 0);
            tick();
        end
        chk_idle("t5.end");

        // 6: reset in the middle of an iteration drops the rest.
        offer(32'hFF, 8'h77);
        tick();
        withdraw();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_beat("t6.beat", i, 8'h77, 0);
            tick();
        end
        reset = 1'b1;
        settle();
        chk("t6.rst_valid", 32'(bus.out_valid), 0);
        chk("t6.rst_in_ready", 32'(bus.in_ready), 0);
        chk("t6.rst_busy", 32'(bus.busy), 0);
        tick();
        reset = 1'b0;
        settle();
        chk_idle("t6.after_rst");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6.no_beat", 32'(bus.out_valid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
